stage5_wb: RTL and testbench



---
 rtl/pipe_pkg.sv | 13 +
 rtl/stage5_wb_if.sv | 47 ++++
 rtl/load_align.sv | 40 ++++
 rtl/stage5_wb.sv | 136 +++++++++++++
 tb/tb_stage5_wb.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline encodings for write-back select and load size.
// Used by decode (producer) and write-back (consumer).
package pipe_pkg;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_LINK = 2'b10;

  localparam logic [1:0] LD_BYTE = 2'b00;
  localparam logic [1:0] LD_HALF = 2'b01;
  localparam logic [1:0] LD_WORD = 2'b10;

endpackage

// File: rtl/stage5_wb_if.sv
// MEM->WB bundle plus register-file write and bypass signals.
// master drives the MEM side, slave is the write-back stage.
interface stage5_wb_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic          hold;
  logic          flush;
  logic          mem_valid;
  logic          wr_en_in;
  logic [1:0]    wb_sel;
  logic [1:0]    ld_size;
  logic          ld_signed;
  logic [DW-1:0] alu_result;
  logic [DW-1:0] mem_rd_data;
  logic [DW-1:0] pc_plus4;
  logic [AW-1:0] dst;
  logic [AW-1:0] rs_addr;
  logic [AW-1:0] rt_addr;
  logic [DW-1:0] rs_data;
  logic [DW-1:0] rt_data;
  logic          reg_wr_en;
  logic [AW-1:0] reg_wr_addr;
  logic [DW-1:0] reg_wr_data;
  logic [DW-1:0] rs_fwd;
  logic [DW-1:0] rt_fwd;
  logic          wb_misalign;
  logic [31:0]   instr_retired;

  modport master (
    output hold, flush, mem_valid, wr_en_in, wb_sel,
           ld_size, ld_signed, alu_result, mem_rd_data,
           pc_plus4, dst, rs_addr, rt_addr, rs_data,
           rt_data,
    input  reg_wr_en, reg_wr_addr, reg_wr_data, rs_fwd,
           rt_fwd, wb_misalign, instr_retired
  );

  modport slave (
    input  hold, flush, mem_valid, wr_en_in, wb_sel,
           ld_size, ld_signed, alu_result, mem_rd_data,
           pc_plus4, dst, rs_addr, rt_addr, rs_data,
           rt_data,
    output reg_wr_en, reg_wr_addr, reg_wr_data, rs_fwd,
           rt_fwd, wb_misalign, instr_retired
  );
endinterface

// File: rtl/load_align.sv
// Little-endian load lane select with sign/zero extension.
// Also flags half/word accesses that are not naturally aligned.
module load_align
  import pipe_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [DW-1:0] word,
  input  logic [1:0]    off,
  input  logic [1:0]    size,
  input  logic          ld_signed,
  output logic [DW-1:0] data,
  output logic          misalign
);

  logic [7:0]  byte_l;
  logic [15:0] half_l;

  // pick the lane, extend it, and check natural alignment
  always_comb begin
    byte_l   = word[{off, 3'b000} +: 8];
    half_l   = word[{off[1], 4'b0000} +: 16];
    data     = word;
    misalign = 1'b0;
    case (size)
      LD_BYTE: begin
        data = {{(DW-8){ld_signed & byte_l[7]}}, byte_l};
      end
      LD_HALF: begin
        data     = {{(DW-16){ld_signed & half_l[15]}}, half_l};
        misalign = off[0];
      end
      default: begin
        data     = word;
        misalign = (off != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/stage5_wb.sv
// Write-back stage: MEM/WB register, result select, WB->ID bypass
// and retired-instruction counter.
module stage5_wb
  import pipe_pkg::*;
#(
  parameter int          DATA_WIDTH       = 32,
  parameter int          ADDR_WIDTH       = 5,
  parameter logic [31:0] RETIRE_RESET_VAL = 32'h0
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  hold,
  input  logic                  flush,
  input  logic                  mem_valid_in,
  input  logic                  reg_wr_en_in,
  input  logic [1:0]            wb_sel_in,
  input  logic [1:0]            ld_size_in,
  input  logic                  ld_signed_in,
  input  logic [DATA_WIDTH-1:0] alu_result_in,
  input  logic [DATA_WIDTH-1:0] mem_rd_data_in,
  input  logic [DATA_WIDTH-1:0] pc_plus4_in,
  input  logic [ADDR_WIDTH-1:0] reg_dst_addr_in,
  input  logic [ADDR_WIDTH-1:0] id_rs_addr,
  input  logic [ADDR_WIDTH-1:0] id_rt_addr,
  input  logic [DATA_WIDTH-1:0] id_rs_data_in,
  input  logic [DATA_WIDTH-1:0] id_rt_data_in,
  output logic                  reg_wr_en,
  output logic [ADDR_WIDTH-1:0] reg_wr_addr,
  output logic [DATA_WIDTH-1:0] reg_wr_data,
  output logic [DATA_WIDTH-1:0] id_rs_data_fwd,
  output logic [DATA_WIDTH-1:0] id_rt_data_fwd,
  output logic                  wb_misalign,
  output logic [31:0]           instr_retired
);

  logic                  valid_q, valid_d;
  logic                  wr_en_q, wr_en_d;
  logic [1:0]            wb_sel_q, wb_sel_d;
  logic [1:0]            ld_size_q, ld_size_d;
  logic                  ld_signed_q, ld_signed_d;
  logic [DATA_WIDTH-1:0] alu_q, alu_d;
  logic [DATA_WIDTH-1:0] mem_q, mem_d;
  logic [DATA_WIDTH-1:0] pc4_q, pc4_d;
  logic [ADDR_WIDTH-1:0] dst_q, dst_d;
  logic [31:0]           cnt_q, cnt_d;

  logic [DATA_WIDTH-1:0] ld_data;
  logic                  ld_mis;

  // next-state: flush clears valid only, hold freezes, else load
  always_comb begin
    valid_d     = valid_q;
    wr_en_d     = wr_en_q;
    wb_sel_d    = wb_sel_q;
    ld_size_d   = ld_size_q;
    ld_signed_d = ld_signed_q;
    alu_d       = alu_q;
    mem_d       = mem_q;
    pc4_d       = pc4_q;
    dst_d       = dst_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (!hold) begin
      valid_d     = mem_valid_in;
      wr_en_d     = reg_wr_en_in;
      wb_sel_d    = wb_sel_in;
      ld_size_d   = ld_size_in;
      ld_signed_d = ld_signed_in;
      alu_d       = alu_result_in;
      mem_d       = mem_rd_data_in;
      pc4_d       = pc_plus4_in;
      dst_d       = reg_dst_addr_in;
    end
    cnt_d = cnt_q + {31'd0, valid_q & ~hold};
  end

  // MEM/WB register and retire counter
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      valid_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      wb_sel_q    <= 2'b00;
      ld_size_q   <= 2'b00;
      ld_signed_q <= 1'b0;
      alu_q       <= '0;
      mem_q       <= '0;
      pc4_q       <= '0;
      dst_q       <= '0;
      cnt_q       <= RETIRE_RESET_VAL;
    end else begin
      valid_q     <= valid_d;
      wr_en_q     <= wr_en_d;
      wb_sel_q    <= wb_sel_d;
      ld_size_q   <= ld_size_d;
      ld_signed_q <= ld_signed_d;
      alu_q       <= alu_d;
      mem_q       <= mem_d;
      pc4_q       <= pc4_d;
      dst_q       <= dst_d;
      cnt_q       <= cnt_d;
    end
  end

  load_align #(
    .DW(DATA_WIDTH)
  ) u_align (
    .word     (mem_q),
    .off      (alu_q[1:0]),
    .size     (ld_size_q),
    .ld_signed(ld_signed_q),
    .data     (ld_data),
    .misalign (ld_mis)
  );

  // result select, write enable and decode bypass
  always_comb begin
    wb_misalign = valid_q & (wb_sel_q == WB_LOAD) & ld_mis;
    unique case (1'b1)
      (wb_sel_q == WB_LOAD): reg_wr_data = ld_data;
      (wb_sel_q == WB_LINK): reg_wr_data = pc4_q;
      default:               reg_wr_data = alu_q;
    endcase
    reg_wr_en   = valid_q & wr_en_q & (dst_q != '0)
                & ~wb_misalign;
    reg_wr_addr = dst_q;
    id_rs_data_fwd = id_rs_data_in;
    id_rt_data_fwd = id_rt_data_in;
    if (reg_wr_en && (dst_q == id_rs_addr))
      id_rs_data_fwd = reg_wr_data;
    if (reg_wr_en && (dst_q == id_rt_addr))
      id_rt_data_fwd = reg_wr_data;
  end

  assign instr_retired = cnt_q;

endmodule

// File: tb/tb_stage5_wb.sv
// Directed bench for stage5_wb: vector table plus hold/flush,
// bypass, async reset and counter-wrap sequences.
module tb_stage5_wb;
  import pipe_pkg::*;

  logic clk;
  logic rstb;
  int   checks;
  int   failures;
  logic        mv;
  logic [31:0] ecnt;
  logic [31:0] saved;

  stage5_wb_if #(.DW(32), .AW(5)) bus ();

  logic        w_en, w_mis;
  logic [4:0]  w_addr;
  logic [31:0] w_data, w_rs, w_rt, w_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  stage5_wb dut (
    .clk            (clk),
    .rstb           (rstb),
    .hold           (bus.hold),
    .flush          (bus.flush),
    .mem_valid_in   (bus.mem_valid),
    .reg_wr_en_in   (bus.wr_en_in),
    .wb_sel_in      (bus.wb_sel),
    .ld_size_in     (bus.ld_size),
    .ld_signed_in   (bus.ld_signed),
    .alu_result_in  (bus.alu_result),
    .mem_rd_data_in (bus.mem_rd_data),
    .pc_plus4_in    (bus.pc_plus4),
    .reg_dst_addr_in(bus.dst),
    .id_rs_addr     (bus.rs_addr),
    .id_rt_addr     (bus.rt_addr),
    .id_rs_data_in  (bus.rs_data),
    .id_rt_data_in  (bus.rt_data),
    .reg_wr_en      (bus.reg_wr_en),
    .reg_wr_addr    (bus.reg_wr_addr),
    .reg_wr_data    (bus.reg_wr_data),
    .id_rs_data_fwd (bus.rs_fwd),
    .id_rt_data_fwd (bus.rt_fwd),
    .wb_misalign    (bus.wb_misalign),
    .instr_retired  (bus.instr_retired)
  );

  // same stimulus, counter preloaded one below wrap
  stage5_wb #(.RETIRE_RESET_VAL(32'hFFFF_FFFF)) dut_w (
    .clk            (clk),
    .rstb           (rstb),
    .hold           (bus.hold),
    .flush          (bus.flush),
    .mem_valid_in   (bus.mem_valid),
    .reg_wr_en_in   (bus.wr_en_in),
    .wb_sel_in      (bus.wb_sel),
    .ld_size_in     (bus.ld_size),
    .ld_signed_in   (bus.ld_signed),
    .alu_result_in  (bus.alu_result),
    .mem_rd_data_in (bus.mem_rd_data),
    .pc_plus4_in    (bus.pc_plus4),
    .reg_dst_addr_in(bus.dst),
    .id_rs_addr     (bus.rs_addr),
    .id_rt_addr     (bus.rt_addr),
    .id_rs_data_in  (bus.rs_data),
    .id_rt_data_in  (bus.rt_data),
    .reg_wr_en      (w_en),
    .reg_wr_addr    (w_addr),
    .reg_wr_data    (w_data),
    .id_rs_data_fwd (w_rs),
    .id_rt_data_fwd (w_rt),
    .wb_misalign    (w_mis),
    .instr_retired  (w_cnt)
  );

  typedef struct {
    logic        v;
    logic        we;
    logic [1:0]  sel;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [31:0] pc;
    logic [4:0]  dst;
    logic        e_en;
    logic [31:0] e_data;
    logic        e_mis;
  } vec_t;

  vec_t tv[14];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (mv && !bus.hold) ecnt = ecnt + 32'd1;
    if (bus.flush) mv = 1'b0;
    else if (!bus.hold) mv = bus.mem_valid;
    #1;
  endtask

  task automatic drive(input vec_t t);
    bus.mem_valid   = t.v;
    bus.wr_en_in    = t.we;
    bus.wb_sel      = t.sel;
    bus.ld_size     = t.sz;
    bus.ld_signed   = t.sg;
    bus.alu_result  = t.alu;
    bus.mem_rd_data = t.mem;
    bus.pc_plus4    = t.pc;
    bus.dst         = t.dst;
  endtask

  task automatic alu_op(input logic [31:0] r, input logic [4:0] d);
    vec_t t;
    t = '{1'b1, 1'b1, WB_ALU, LD_WORD, 1'b0, r, 32'h0, 32'h0,
          d, 1'b1, r, 1'b0};
    drive(t);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    mv = 1'b0;
    ecnt = 32'd0;
    rstb = 1'b0;
    bus.hold = 1'b0;
    bus.flush = 1'b0;
    bus.rs_addr = 5'd0;
    bus.rt_addr = 5'd0;
    bus.rs_data = 32'hCAFE_0001;
    bus.rt_data = 32'hCAFE_0002;
    alu_op(32'h1234_5678, 5'd5);

    //            v   we  sel      sz       sg  alu           mem           pc            dst  en  data          mis
    tv[0]  = '{1, 1, WB_ALU,  LD_WORD, 0, 32'h1234_5678, 32'h0,         32'h0,         5,  1, 32'h1234_5678, 0};
    tv[1]  = '{1, 1, WB_LOAD, LD_BYTE, 1, 32'h0000_0102, 32'h8081_F2F3, 32'h0,         3,  1, 32'hFFFF_FF81, 0};
    tv[2]  = '{1, 1, WB_LOAD, LD_BYTE, 0, 32'h0000_0102, 32'h8081_F2F3, 32'h0,         3,  1, 32'h0000_0081, 0};
    tv[3]  = '{1, 1, WB_LOAD, LD_HALF, 1, 32'h0000_0102, 32'h8081_F2F3, 32'h0,         3,  1, 32'hFFFF_8081, 0};
    tv[4]  = '{1, 1, WB_LOAD, LD_HALF, 1, 32'h0000_0101, 32'h8081_F2F3, 32'h0,         3,  0, 32'hFFFF_F2F3, 1};
    tv[5]  = '{1, 1, WB_LINK, LD_WORD, 0, 32'h0000_0000, 32'h0,         32'h0040_0008, 31, 1, 32'h0040_0008, 0};
    tv[6]  = '{1, 1, WB_ALU,  LD_WORD, 0, 32'h0000_AAAA, 32'h0,         32'h0,         0,  0, 32'h0000_AAAA, 0};
    tv[7]  = '{1, 1, WB_LOAD, LD_WORD, 0, 32'h0000_0200, 32'h8081_F2F3, 32'h0,         4,  1, 32'h8081_F2F3, 0};
    tv[8]  = '{1, 1, WB_LOAD, LD_WORD, 0, 32'h0000_0203, 32'h8081_F2F3, 32'h0,         4,  0, 32'h8081_F2F3, 1};
    tv[9]  = '{1, 1, WB_LOAD, LD_BYTE, 1, 32'h0000_0001, 32'h8081_F2F3, 32'h0,         6,  1, 32'hFFFF_FFF2, 0};
    tv[10] = '{1, 1, 2'b11,   LD_WORD, 0, 32'h0BAD_F00D, 32'h1111_1111, 32'h2222_2222, 6,  1, 32'h0BAD_F00D, 0};
    tv[11] = '{1, 1, WB_LOAD, LD_HALF, 0, 32'h0000_0000, 32'h8081_F2F3, 32'h0,         8,  1, 32'h0000_F2F3, 0};
    tv[12] = '{0, 1, WB_LOAD, LD_WORD, 0, 32'h0000_0003, 32'h8081_F2F3, 32'h0,         8,  0, 32'h8081_F2F3, 0};
    tv[13] = '{1, 0, WB_ALU,  LD_WORD, 0, 32'h0000_7777, 32'h0,         32'h0,         9,  0, 32'h0000_7777, 0};

    // reset with clock running
    repeat (2) @(posedge clk);
    #1;
    chk("rst_en", {31'd0, bus.reg_wr_en}, 32'd0);
    chk("rst_addr", {27'd0, bus.reg_wr_addr}, 32'd0);
    chk("rst_data", bus.reg_wr_data, 32'd0);
    chk("rst_mis", {31'd0, bus.wb_misalign}, 32'd0);
    chk("rst_cnt", bus.instr_retired, 32'd0);
    chk("rst_rs_fwd", bus.rs_fwd, 32'hCAFE_0001);
    chk("rst_rt_fwd", bus.rt_fwd, 32'hCAFE_0002);
    #3 rstb = 1'b1;

    // vector table
    for (int i = 0; i < 14; i++) begin
      drive(tv[i]);
      step();
      chk($sformatf("v%0d_en", i), {31'd0, bus.reg_wr_en},
          {31'd0, tv[i].e_en});
      chk($sformatf("v%0d_addr", i), {27'd0, bus.reg_wr_addr},
          {27'd0, tv[i].dst});
      chk($sformatf("v%0d_data", i), bus.reg_wr_data, tv[i].e_data);
      chk($sformatf("v%0d_mis", i), {31'd0, bus.wb_misalign},
          {31'd0, tv[i].e_mis});
      chk($sformatf("v%0d_cnt", i), bus.instr_retired, ecnt);
    end
    chk("cnt_total", bus.instr_retired, 32'd12);

    // bypass
    alu_op(32'hDEAD_BEEF, 5'd7);
    step();
    bus.rs_addr = 5'd7;
    bus.rs_data = 32'h0;
    bus.rt_addr = 5'd8;
    bus.rt_data = 32'h1111_2222;
    #1;
    chk("byp_rs", bus.rs_fwd, 32'hDEAD_BEEF);
    chk("byp_rt_miss", bus.rt_fwd, 32'h1111_2222);
    bus.rt_addr = 5'd7;
    #1;
    chk("byp_rt_hit", bus.rt_fwd, 32'hDEAD_BEEF);
    alu_op(32'h5555_0000, 5'd0);
    bus.rs_addr = 5'd0;
    step();
    chk("byp_r0", bus.rs_fwd, 32'h0);
    bus.rs_addr = 5'd3;
    bus.rt_addr = 5'd3;

    // hold freezes register and counter
    alu_op(32'h0000_0055, 5'd9);
    step();
    saved = bus.instr_retired;
    bus.hold = 1'b1;
    alu_op(32'h0000_0099, 5'd10);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("hold%0d_data", k), bus.reg_wr_data, 32'h55);
      chk($sformatf("hold%0d_addr", k), {27'd0, bus.reg_wr_addr},
          32'd9);
      chk($sformatf("hold%0d_en", k), {31'd0, bus.reg_wr_en}, 32'd1);
      chk($sformatf("hold%0d_cnt", k), bus.instr_retired, saved);
    end

    // flush beats hold
    bus.flush = 1'b1;
    step();
    chk("flh_en", {31'd0, bus.reg_wr_en}, 32'd0);
    chk("flh_cnt", bus.instr_retired, saved);
    bus.flush = 1'b0;
    bus.hold = 1'b0;
    step();
    chk("post_data", bus.reg_wr_data, 32'h99);
    chk("post_en", {31'd0, bus.reg_wr_en}, 32'd1);
    chk("post_cnt", bus.instr_retired, ecnt);

    // flush alone: valid leaves WB and counts, bubble follows
    bus.flush = 1'b1;
    step();
    chk("fl_en", {31'd0, bus.reg_wr_en}, 32'd0);
    chk("fl_cnt", bus.instr_retired, saved + 32'd1);
    bus.flush = 1'b0;

    // async reset mid-operation
    alu_op(32'h0000_00AB, 5'd11);
    step();
    #2 rstb = 1'b0;
    #1;
    chk("arst_en", {31'd0, bus.reg_wr_en}, 32'd0);
    chk("arst_data", bus.reg_wr_data, 32'd0);
    chk("arst_cnt", bus.instr_retired, 32'd0);
    mv = 1'b0;
    ecnt = 32'd0;
    #1 rstb = 1'b1;

    // counter wrap on preloaded instance
    alu_op(32'h0000_0001, 5'd1);
    step();
    chk("wrap_pre", w_cnt, 32'hFFFF_FFFF);
    step();
    chk("wrap_zero", w_cnt, 32'h0);
    chk("wrap_main", bus.instr_retired, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
